serial_aleb_cmp: RTL and testbench

SERIAL_ALEB_CMP -- requirements
Module: serial_aleb_cmp

---
 rtl/serial_aleb_cmp_if.sv | 23 ++
 rtl/serial_aleb_cmp.sv | 114 +++++++++++
 tb/tb_serial_aleb_cmp.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/serial_aleb_cmp_if.sv
// Request/result bundle for the serial A<=B comparator.
// Ports: START/A/B/CIN toward the comparator; BUSY/DONE/LE back.
interface serial_aleb_cmp_if #(
  parameter int WIDTH = 16
);
  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             CIN;
  logic             BUSY;
  logic             DONE;
  logic             LE;

  modport master (
    output START, A, B, CIN,
    input  BUSY, DONE, LE
  );

  modport slave (
    input  START, A, B, CIN,
    output BUSY, DONE, LE
  );
endinterface

// File: rtl/serial_aleb_cmp.sv
// Serial unsigned A<=B comparator, 2 bits per clock, LSB first.
// Ports: CLK, RST (sync, active-high), bus (slave: START/A/B/CIN in,
// BUSY/DONE/LE out). LE = (A<B) | (A==B & CIN), valid at the DONE pulse.
module serial_aleb_cmp #(
  parameter int WIDTH = 16
) (
  input  logic               CLK,
  input  logic               RST,
  serial_aleb_cmp_if.slave   bus
);

  localparam int N  = WIDTH / 2;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic             le_q, le_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [1:0] a_sl;
  logic [1:0] b_sl;
  logic       c1;
  logic       c2;

  assign a_sl = a_q[2*int'(idx_q) +: 2];
  assign b_sl = b_q[2*int'(idx_q) +: 2];

  // Carry = "lower bits of A <= lower bits of B so far"; a higher
  // bit that differs overrides, an equal bit passes the carry on.
  assign c1 = (b_sl[0] & ~a_sl[0])
            | ((b_sl[0] | ~a_sl[0]) & c_q);
  assign c2 = (b_sl[1] & ~a_sl[1])
            | ((b_sl[1] | ~a_sl[1]) & c1);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    le_d    = le_q;
    done_d  = 1'b0;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (bus.START) begin
          a_d     = bus.A;
          b_d     = bus.B;
          c_d     = bus.CIN;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        c_d = c2;
        // Index holds at the last slice rather than wrapping.
        if (idx_q == LAST) begin
          state_d = FIN;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      FIN: begin
        le_d    = c_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      le_q    <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      le_q    <= le_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;
  assign bus.LE   = le_q;

endmodule

// File: tb/tb_serial_aleb_cmp.sv
// Self-checking bench for serial_aleb_cmp (WIDTH=16).
// Directed steps plus random compares against an expected-result queue.
module tb_serial_aleb_cmp;

  localparam int W = 16;

  logic clk = 1'b0;
  logic rst;

  serial_aleb_cmp_if #(.WIDTH(W)) bus ();

  serial_aleb_cmp #(.WIDTH(W)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic exp_q[$];
  logic last_le = 1'b0;

  function automatic logic model(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         c
  );
    return (a < b) | ((a == b) & c);
  endfunction

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge just after the START acceptance edge.
  task automatic collect(input bit lat_chk, input bit pulse_chk);
    int   cnt;
    int   bsy;
    logic e;
    cnt = 0;
    bsy = 0;
    while (bus.DONE !== 1'b1 && cnt < 30) begin
      if (bus.BUSY === 1'b1) bsy++;
      if (lat_chk && cnt == 4)
        chk("le_hold", 32'(bus.LE), 32'(last_le));
      @(negedge clk);
      cnt++;
    end
    if (bus.DONE !== 1'b1) begin
      chk("done_timeout", 32'(bus.DONE), 32'd1);
    end else begin
      if (exp_q.size() == 0) begin
        chk("sb_empty", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("le_result", 32'(bus.LE), 32'(e));
        last_le = e;
      end
      if (lat_chk) begin
        chk("latency", 32'(cnt), 32'd9);
        chk("busy_cycles", 32'(bsy), 32'd9);
        chk("busy_at_done", 32'(bus.BUSY), 32'd0);
      end
      if (pulse_chk) begin
        @(negedge clk);
        chk("done_pulse", 32'(bus.DONE), 32'd0);
      end
    end
  endtask

  task automatic run_one(
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         c,
    input bit           full
  );
    @(negedge clk);
    bus.A     = a;
    bus.B     = b;
    bus.CIN   = c;
    bus.START = 1'b1;
    exp_q.push_back(model(a, b, c));
    @(negedge clk);
    bus.START = 1'b0;
    // Scramble operands after capture; result must not change.
    bus.A   = W'($urandom);
    bus.B   = W'($urandom);
    bus.CIN = 1'($urandom);
    if (full) chk("busy_after_accept", 32'(bus.BUSY), 32'd1);
    collect(full, full);
  endtask

  initial begin
    int   dn;
    logic [W-1:0] ra, rb;
    logic         rc;

    rst       = 1'b1;
    bus.START = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    bus.CIN   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.BUSY), 32'd0);
    chk("rst_done", 32'(bus.DONE), 32'd0);
    chk("rst_le", 32'(bus.LE), 32'd0);

    // Reset wins over a simultaneous START.
    bus.START = 1'b1;
    bus.A     = 16'h0000;
    bus.B     = 16'h0001;
    @(negedge clk);
    rst       = 1'b0;
    bus.START = 1'b0;
    chk("rst_prio_busy", 32'(bus.BUSY), 32'd0);
    @(negedge clk);
    chk("rst_prio_idle", 32'(bus.BUSY), 32'd0);

    run_one(16'h1234, 16'h1234, 1'b1, 1'b1);
    run_one(16'h1234, 16'h1234, 1'b0, 1'b1);
    run_one(16'h0001, 16'h0002, 1'b0, 1'b1);
    run_one(16'h8000, 16'h7FFF, 1'b1, 1'b1);
    run_one(16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    run_one(16'h0000, 16'hFFFF, 1'b0, 1'b1);

    // START held high; A changes mid-run; re-accept in DONE cycle.
    @(negedge clk);
    bus.A     = 16'h0003;
    bus.B     = 16'h0001;
    bus.CIN   = 1'b0;
    bus.START = 1'b1;
    exp_q.push_back(model(16'h0003, 16'h0001, 1'b0));
    @(negedge clk);
    bus.A = 16'h0000;
    collect(1'b1, 1'b0);
    exp_q.push_back(model(16'h0000, 16'h0001, 1'b0));
    @(negedge clk);
    bus.START = 1'b0;
    chk("reaccept_busy", 32'(bus.BUSY), 32'd1);
    chk("reaccept_done_low", 32'(bus.DONE), 32'd0);
    collect(1'b1, 1'b1);

    // Abort with reset at the 4th RUN edge.
    @(negedge clk);
    bus.A     = 16'h1234;
    bus.B     = 16'h1234;
    bus.CIN   = 1'b1;
    bus.START = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(bus.BUSY), 32'd0);
    chk("abort_le", 32'(bus.LE), 32'd0);
    chk("abort_done", 32'(bus.DONE), 32'd0);
    last_le = 1'b0;
    dn = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.DONE === 1'b1) dn++;
    end
    chk("abort_no_done", 32'(dn), 32'd0);

    // Random reference check, with some forced-equal operands.
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
      rc = 1'($urandom);
      run_one(ra, rb, rc, 1'b0);
    end
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
